// File: rtl/red_pitaya_product_sat_pipe.sv
// Multi-lane pipelined signed multiplier with selectable rounding, saturation
// and overflow accounting. Fixed latency of 3 cycles from valid_i to valid_o:
//   S1 registers factors, rounding mode and valid
//   S2 registers the full-width product per lane
//   S3 registers the rounded, saturated result and per-lane overflow
// Sticky flags and the shared event counter follow the S3 outputs.
module red_pitaya_product_sat_pipe #(
  parameter int CHANNELS = 2,
  parameter int BITS_IN1 = 14,
  parameter int BITS_IN2 = 16,
  parameter int BITS_OUT = 14,
  parameter int SHIFT    = 14,
  parameter int CNT_BITS = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  input  logic [CHANNELS*BITS_IN1-1:0] factor1_i,
  input  logic [CHANNELS*BITS_IN2-1:0] factor2_i,
  input  logic [1:0]                   round_i,
  input  logic                         clr_i,
  output logic [CHANNELS*BITS_OUT-1:0] product_o,
  output logic                         valid_o,
  output logic [CHANNELS-1:0]          ovf_o,
  output logic [CHANNELS-1:0]          sticky_o,
  output logic [CNT_BITS-1:0]          ovf_cnt_o
);

  localparam int PW = BITS_IN1 + BITS_IN2;   // full product width
  localparam int W  = PW + 1;                // rounding sum width, cannot wrap
  localparam int HW = W - SHIFT;             // width of sum >> SHIFT

  localparam logic [SHIFT-1:0]    HALF    = SHIFT'(1) << (SHIFT - 1);
  localparam logic [BITS_OUT-1:0] SAT_MAX = {1'b0, {(BITS_OUT-1){1'b1}}};
  localparam logic [BITS_OUT-1:0] SAT_MIN = {1'b1, {(BITS_OUT-1){1'b0}}};
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  // S1
  logic                         r_s1_valid;
  logic [CHANNELS*BITS_IN1-1:0] r_f1;
  logic [CHANNELS*BITS_IN2-1:0] r_f2;
  logic [1:0]                   r_s1_round;

  // S2
  logic                         r_s2_valid;
  logic [PW-1:0]                r_prod [CHANNELS];
  logic [1:0]                   r_s2_round;

  // S3 and accounting
  logic                         r_s3_valid;
  logic [CHANNELS*BITS_OUT-1:0] r_out;
  logic [CHANNELS-1:0]          r_ovf;
  logic [CHANNELS-1:0]          r_sticky;
  logic [CNT_BITS-1:0]          r_cnt;

  // Rounding / saturation datapath
  logic [SHIFT-1:0]             w_c     [CHANNELS];
  logic                         w_carry [CHANNELS];
  logic [HW-1:0]                w_hi    [CHANNELS];
  logic [CHANNELS-1:0]          w_ovf;
  logic [CHANNELS*BITS_OUT-1:0] w_res;
  logic [CNT_BITS-1:0]          w_cnt_base;
  logic [CNT_BITS-1:0]          w_cnt_next;

  // S1: capture factors and rounding mode together so the mode travels with the sample
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_f1       <= '0;
      r_f2       <= '0;
      r_s1_round <= '0;
    end else begin
      r_s1_valid <= valid_i;
      if (valid_i) begin
        r_f1       <= factor1_i;
        r_f2       <= factor2_i;
        r_s1_round <= round_i;
      end
    end
  end

  // S2: full-precision signed product per lane
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s2_valid <= 1'b0;
      r_s2_round <= '0;
      for (int k = 0; k < CHANNELS; k++) r_prod[k] <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_round <= r_s1_round;
        for (int k = 0; k < CHANNELS; k++)
          r_prod[k] <= PW'($signed(r_f1[k*BITS_IN1 +: BITS_IN1])) *
                       PW'($signed(r_f2[k*BITS_IN2 +: BITS_IN2]));
      end
    end
  end

  // Round and clamp. The W-bit sum (P + c) >> SHIFT is formed as the upper
  // product bits plus the carry out of the fraction, which is exact because
  // the rounding constant c never exceeds 2^(SHIFT-1).
  always_comb begin
    w_ovf = '0;
    w_res = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      case (r_s2_round)
        2'b00:   w_c[k] = '0;
        2'b10:   w_c[k] = HALF - SHIFT'(1) + SHIFT'(r_prod[k][SHIFT]);
        default: w_c[k] = HALF;
      endcase
      w_carry[k] = ({1'b0, r_prod[k][SHIFT-1:0]} + {1'b0, w_c[k]}) >
                   {1'b0, {SHIFT{1'b1}}};
      w_hi[k] = {r_prod[k][PW-1], r_prod[k][PW-1:SHIFT]} + HW'(w_carry[k]);
      w_ovf[k] = !((&w_hi[k][HW-1:BITS_OUT-1]) || !(|w_hi[k][HW-1:BITS_OUT-1]));
      if (w_ovf[k])
        w_res[k*BITS_OUT +: BITS_OUT] = w_hi[k][HW-1] ? SAT_MIN : SAT_MAX;
      else
        w_res[k*BITS_OUT +: BITS_OUT] = w_hi[k][BITS_OUT-1:0];
    end
  end

  // S3: result holds between samples, overflow is a pulse aligned with valid
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s3_valid <= 1'b0;
      r_out      <= '0;
      r_ovf      <= '0;
    end else begin
      r_s3_valid <= r_s2_valid;
      r_ovf      <= r_s2_valid ? w_ovf : '0;
      if (r_s2_valid) r_out <= w_res;
    end
  end

  // Counter next value: clear first, then a saturating increment on any-lane overflow
  always_comb begin
    w_cnt_base = clr_i ? '0 : r_cnt;
    w_cnt_next = w_cnt_base;
    if ((|r_ovf) && (w_cnt_base != CNT_MAX)) w_cnt_next = w_cnt_base + CNT_BITS'(1);
  end

  // Sticky flags and event counter; a coincident overflow wins over clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sticky <= '0;
      r_cnt    <= '0;
    end else begin
      r_sticky <= (clr_i ? '0 : r_sticky) | r_ovf;
      r_cnt    <= w_cnt_next;
    end
  end

  assign product_o = r_out;
  assign valid_o   = r_s3_valid;
  assign ovf_o     = r_ovf;
  assign sticky_o  = r_sticky;
  assign ovf_cnt_o = r_cnt;

endmodule
